// File: rtl/data_mem_request_unit_pkg.sv
// Shared types and helpers for the data-memory request unit.
// Holds the request FSM state encoding and the word-alignment rule.
package data_mem_request_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [3:0] SEL_WORD = 4'hF;

  // Byte accesses can never be misaligned; word accesses need address[1:0] == 0.
  function automatic logic word_misaligned(input logic byte_op, input logic [1:0] lsb);
    return !byte_op && (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/data_mem_request_unit_if.sv
// Single-outstanding req/ack data bus between the request unit (master)
// and data memory (slave).
interface data_mem_request_unit_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_sel;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/data_mem_request_unit_byte_lane.sv
// Combinational byte-lane steering: store lane enables and sb data replication
// at issue time, lb byte extraction and sign extension at completion time.
module data_mem_request_unit_byte_lane
  import data_mem_request_unit_pkg::*;
(
  input  logic        is_write,
  input  logic        store_byte,
  input  logic [1:0]  issue_off,
  input  logic [31:0] store_data,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  input  logic        load_byte,
  input  logic [1:0]  load_off,
  input  logic [31:0] rdata,
  output logic [31:0] load_value
);
  logic [31:0] wdata_rep;
  logic [7:0]  lanes [4];
  logic [7:0]  picked;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_rep[8*gi +: 8] = store_data[7:0];
      assign lanes[gi]            = rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    sel   = SEL_WORD;
    wdata = store_data;
    if (is_write && store_byte) begin
      sel   = 4'b0001 << issue_off;
      wdata = wdata_rep;
    end
  end

  assign picked     = lanes[load_off];
  assign load_value = load_byte ? {{24{picked[7]}}, picked} : rdata;

endmodule

// File: rtl/data_mem_request_unit.sv
// Load/store request unit: issues one req/ack bus transaction per memory
// instruction, stalls the pipeline until it completes and returns load data.
module data_mem_request_unit
  import data_mem_request_unit_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              read_mem,
  input  logic              write_mem,
  input  logic              load_byte,
  input  logic              store_byte,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              mem_error,
  data_mem_request_unit_if.master bus
);
  localparam int                 TIMER_W    = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  mem_state_t        state_reg, state_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic              we_reg, we_next;
  logic              byte_reg, byte_next;
  logic [1:0]        off_reg, off_next;
  logic [3:0]        sel_reg, sel_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [31:0]       load_data_reg, load_data_next;
  logic              error_reg, error_next;

  logic        op;
  logic        byte_op;
  logic [3:0]  issue_sel;
  logic [31:0] issue_wdata;
  logic [31:0] load_value;

  assign op      = read_mem | write_mem;
  // A store wins when decode raises both controls.
  assign byte_op = write_mem ? store_byte : load_byte;

  data_mem_request_unit_byte_lane u_lane (
    .is_write   (write_mem),
    .store_byte (store_byte),
    .issue_off  (address[1:0]),
    .store_data (store_data),
    .sel        (issue_sel),
    .wdata      (issue_wdata),
    .load_byte  (byte_reg),
    .load_off   (off_reg),
    .rdata      (bus.mem_rdata),
    .load_value (load_value)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      we_reg        <= 1'b0;
      byte_reg      <= 1'b0;
      off_reg       <= 2'b00;
      sel_reg       <= 4'h0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      load_data_reg <= '0;
      error_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      we_reg        <= we_next;
      byte_reg      <= byte_next;
      off_reg       <= off_next;
      sel_reg       <= sel_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      load_data_reg <= load_data_next;
      error_reg     <= error_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    timer_next     = '0;
    we_next        = we_reg;
    byte_next      = byte_reg;
    off_next       = off_reg;
    sel_next       = sel_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    load_data_next = load_data_reg;
    error_next     = 1'b0;
    stall          = 1'b0;

    unique case (state_reg)
      IDLE: begin
        stall = op;
        if (op) begin
          if (word_misaligned(byte_op, address[1:0])) begin
            error_next     = 1'b1;
            load_data_next = '0;
            state_next     = DONE;
          end else begin
            we_next    = write_mem;
            byte_next  = byte_op;
            off_next   = address[1:0];
            sel_next   = issue_sel;
            addr_next  = {address[ADDR_W-1:2], 2'b00};
            wdata_next = issue_wdata;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        // An ack arriving on the last allowed cycle still completes normally.
        if (bus.mem_ack) begin
          if (!we_reg) load_data_next = load_value;
          state_next = DONE;
        end else if (timer_reg == TIMER_LAST) begin
          error_next     = 1'b1;
          load_data_next = '0;
          state_next     = DONE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.mem_req   = (state_reg == REQ);
  assign bus.mem_we    = we_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.mem_sel   = sel_reg;
  assign load_data     = load_data_reg;
  assign mem_error     = error_reg;

endmodule

// File: tb/tb_data_mem_request_unit.sv
// Bench for data_mem_request_unit: transaction-level expectations, per-cycle
// comparison on the falling edge, directed cases plus randomized traffic.
module tb_data_mem_request_unit;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        read_mem = 1'b0, write_mem = 1'b0, load_byte = 1'b0, store_byte = 1'b0;
  logic [31:0] address = '0, store_data = '0;
  logic        stall, mem_error;
  logic [31:0] load_data;

  data_mem_request_unit_if #(.ADDR_W(ADDR_W)) bus ();

  data_mem_request_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .nRst       (nRst),
    .read_mem   (read_mem),
    .write_mem  (write_mem),
    .load_byte  (load_byte),
    .store_byte (store_byte),
    .address    (address),
    .store_data (store_data),
    .stall      (stall),
    .load_data  (load_data),
    .mem_error  (mem_error),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int txn_count = 0;

  // Expected values for the current cycle, set by the driver.
  bit          chk_en = 1'b0;
  bit          e_stall, e_req, e_err, e_we;
  logic [31:0] e_load, e_addr, e_wdata;
  logic [3:0]  e_sel;
  logic [31:0] model_load = '0;

  // Observation counters used by the directed literal checks.
  int          stall_cycles, req_cycles, err_cycles, req_starts;
  bit          prev_req = 1'b0;
  logic        last_we;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_sel;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input bit s, input bit r, input bit er);
    e_stall = s;
    e_req   = r;
    e_err   = er;
    e_load  = model_load;
  endtask

  task automatic clr_counts();
    stall_cycles = 0;
    req_cycles   = 0;
    err_cycles   = 0;
    req_starts   = 0;
  endtask

  function automatic logic [31:0] lb_model(input logic [31:0] rd, input logic [1:0] off);
    logic [31:0] b;
    b = (rd >> (8 * int'(off))) & 32'hFF;
    return (b >= 32'd128) ? (b + 32'hFFFF_FF00) : b;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'd0, stall}, {31'd0, e_stall});
      chk("mem_req", {31'd0, bus.mem_req}, {31'd0, e_req});
      chk("mem_error", {31'd0, mem_error}, {31'd0, e_err});
      chk("load_data", load_data, e_load);
      if (e_req) begin
        chk("mem_we", {31'd0, bus.mem_we}, {31'd0, e_we});
        chk("mem_addr", bus.mem_addr, e_addr);
        chk("mem_sel", {28'd0, bus.mem_sel}, {28'd0, e_sel});
        if (e_we) chk("mem_wdata", bus.mem_wdata, e_wdata);
      end
      if (stall) stall_cycles++;
      if (mem_error) err_cycles++;
      if (bus.mem_req) begin
        req_cycles++;
        if (!prev_req) req_starts++;
        last_we    = bus.mem_we;
        last_addr  = bus.mem_addr;
        last_sel   = bus.mem_sel;
        last_wdata = bus.mem_wdata;
      end
      prev_req = bus.mem_req;
    end
  end

  task automatic idle();
    read_mem    = 1'b0;
    write_mem   = 1'b0;
    address     = $urandom();
    bus.mem_ack = 1'($urandom_range(0, 1));
    set_exp(1'b0, 1'b0, 1'b0);
    cyc();
    bus.mem_ack = 1'b0;
  endtask

  // One memory instruction; ack_at is the REQ cycle (1-based) carrying mem_ack.
  task automatic do_txn(input bit w, input bit b, input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rd, input int ack_at);
    bit          mis, tout;
    int          n;
    logic [3:0]  sel_e;
    logic [31:0] wd_e;
    mis   = !b && (a[1:0] != 2'b00);
    tout  = !mis && (ack_at > TIMEOUT);
    n     = (ack_at < TIMEOUT) ? ack_at : TIMEOUT;
    sel_e = (w && b) ? (4'b0001 << a[1:0]) : 4'hF;
    wd_e  = (w && b) ? (32'h0101_0101 * {24'd0, sd[7:0]}) : sd;

    write_mem     = w;
    read_mem      = w ? 1'($urandom_range(0, 1)) : 1'b1;
    store_byte    = w ? b : 1'($urandom_range(0, 1));
    load_byte     = w ? 1'($urandom_range(0, 1)) : b;
    address       = a;
    store_data    = sd;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = $urandom();
    set_exp(1'b1, 1'b0, 1'b0);
    cyc();

    if (!mis) begin
      for (int i = 1; i <= n; i++) begin
        address       = $urandom();
        store_data    = $urandom();
        bus.mem_ack   = (i == ack_at);
        bus.mem_rdata = (i == ack_at) ? rd : $urandom();
        set_exp(1'b1, 1'b1, 1'b0);
        e_we    = w;
        e_addr  = a & ~32'd3;
        e_sel   = sel_e;
        e_wdata = wd_e;
        cyc();
      end
    end

    if (mis || tout) model_load = '0;
    else if (!w)     model_load = b ? lb_model(rd, a[1:0]) : rd;
    // Decode controls stay up through DONE; the unit must not re-issue.
    bus.mem_ack   = 1'($urandom_range(0, 1));
    bus.mem_rdata = $urandom();
    set_exp(1'b0, 1'b0, mis || tout);
    cyc();
    read_mem    = 1'b0;
    write_mem   = 1'b0;
    bus.mem_ack = 1'b0;
    txn_count++;
    $display("txn %0d: %s %s addr=%h sdata=%h rdata=%h ack_at=%0d misaligned=%0d timeout=%0d load_data=%h",
             txn_count, w ? "store" : "load", b ? "byte" : "word", a, sd, rd, ack_at, mis, tout, load_data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          rw, rb;
    logic [31:0] ra;
    int          rack;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    clr_counts();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_req", {31'd0, bus.mem_req}, 32'd0);
    chk("reset_error", {31'd0, mem_error}, 32'd0);
    chk("reset_load", load_data, 32'd0);
    #2;
    nRst = 1'b1;
    set_exp(1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    cyc();

    // lw with ack two cycles after the request appears
    clr_counts();
    do_txn(1'b0, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 3);
    idle();
    idle();
    chk("t1_stall_cycles", stall_cycles, 32'd4);
    chk("t1_req_cycles", req_cycles, 32'd3);
    chk("t1_req_starts", req_starts, 32'd1);
    chk("t1_load", load_data, 32'hDEAD_BEEF);
    chk("t1_addr", last_addr, 32'h100);
    chk("t1_sel", {28'd0, last_sel}, 32'hF);

    // lb sign/zero extension
    do_txn(1'b0, 1'b1, 32'h103, 32'h0, 32'h80FF_0000, 1);
    chk("t2_lb103", load_data, 32'hFFFF_FF80);
    do_txn(1'b0, 1'b1, 32'h102, 32'h0, 32'h80FF_0000, 2);
    chk("t2_lb102", load_data, 32'hFFFF_FFFF);
    do_txn(1'b0, 1'b1, 32'h101, 32'h0, 32'h0000_7F00, 1);
    chk("t2_lb101", load_data, 32'h0000_007F);

    // sb / sw lanes
    do_txn(1'b1, 1'b1, 32'h202, 32'h1234_56AB, 32'h0, 1);
    chk("t3_sb_we", {31'd0, last_we}, 32'd1);
    chk("t3_sb_sel", {28'd0, last_sel}, 32'h4);
    chk("t3_sb_addr", last_addr, 32'h200);
    chk("t3_sb_wdata", last_wdata, 32'hABAB_ABAB);
    chk("t3_load_held", load_data, 32'h0000_007F);
    do_txn(1'b1, 1'b0, 32'h204, 32'hCAFE_F00D, 32'h0, 2);
    chk("t3_sw_sel", {28'd0, last_sel}, 32'hF);
    chk("t3_sw_wdata", last_wdata, 32'hCAFE_F00D);

    // misaligned sw
    clr_counts();
    do_txn(1'b1, 1'b0, 32'h206, 32'h5555_AAAA, 32'h0, 1);
    idle();
    chk("t4_req_cycles", req_cycles, 32'd0);
    chk("t4_err_cycles", err_cycles, 32'd1);
    chk("t4_stall_cycles", stall_cycles, 32'd1);

    // timeout, then ack on the final allowed cycle
    do_txn(1'b0, 1'b0, 32'h504, 32'h0, 32'h0101_0101, 1);
    clr_counts();
    do_txn(1'b0, 1'b0, 32'h500, 32'h0, 32'h0, 100);
    chk("t5_req_cycles", req_cycles, 32'd4);
    chk("t5_err_cycles", err_cycles, 32'd1);
    chk("t5_load_cleared", load_data, 32'd0);
    clr_counts();
    do_txn(1'b0, 1'b0, 32'h508, 32'h0, 32'h55AA_55AA, 4);
    chk("t5b_req_cycles", req_cycles, 32'd4);
    chk("t5b_err_cycles", err_cycles, 32'd0);
    chk("t5b_load", load_data, 32'h55AA_55AA);

    // reset while a request is outstanding
    do_txn(1'b0, 1'b0, 32'h300, 32'h0, 32'h1122_3344, 1);
    read_mem    = 1'b1;
    write_mem   = 1'b0;
    load_byte   = 1'b0;
    address     = 32'h400;
    bus.mem_ack = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0);
    cyc();
    set_exp(1'b1, 1'b1, 1'b0);
    e_we   = 1'b0;
    e_addr = 32'h400;
    e_sel  = 4'hF;
    @(negedge clk);
    #1;
    chk_en   = 1'b0;
    read_mem = 1'b0;
    nRst     = 1'b0;
    #1;
    chk("t6_req_in_reset", {31'd0, bus.mem_req}, 32'd0);
    chk("t6_stall_in_reset", {31'd0, stall}, 32'd0);
    chk("t6_load_in_reset", load_data, 32'd0);
    chk("t6_err_in_reset", {31'd0, mem_error}, 32'd0);
    repeat (2) @(posedge clk);
    #3;
    nRst       = 1'b1;
    model_load = '0;
    prev_req   = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    cyc();
    clr_counts();
    do_txn(1'b0, 1'b0, 32'h600, 32'h0, 32'h0BAD_F00D, 1);
    do_txn(1'b0, 1'b1, 32'h604, 32'h0, 32'h0000_0042, 2);
    idle();
    chk("t6_req_starts", req_starts, 32'd2);
    chk("t6_load", load_data, 32'h0000_0042);

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      rw = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      ra = $urandom();
      if (!rb && ($urandom_range(0, 9) < 8)) ra[1:0] = 2'b00;
      rack = int'($urandom_range(1, 6));
      do_txn(rw, rb, ra, $urandom(), $urandom(), rack);
      repeat ($urandom_range(0, 2)) idle();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
